i2s_rx_10xe: RTL

- I2S receiver; counterpart of the team's I2S transmitter.
- Oversamples an external serial audio bus (sclk_in, lrclk_in, sdata_0_in) on aud_mclk and deserialises it into per-channel PCM words.
- Buffers words in a small FIFO and presents them on an AXI4-Stream master.
- Sits between the board-level I2S pins and the audio stream fabric.

---
 rtl/i2s_rx_10xe.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/i2s_rx_10xe.sv
// I2S receiver: oversamples the serial bus on aud_mclk, deserialises per-channel
// words and presents them on an AXI4-Stream master through a small FWFT FIFO.
module i2s_rx_10xe #(
   parameter int DATA_WIDTH = 24,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        aud_mclk,
   input  logic        aud_mrst_n,
   input  logic        enable,
   input  logic        sclk_in,
   input  logic        lrclk_in,
   input  logic        sdata_0_in,
   output logic [31:0] m_axis_aud_tdata,
   output logic        m_axis_aud_tid,
   output logic        m_axis_aud_tvalid,
   input  logic        m_axis_aud_tready,
   output logic        overflow,
   output logic        irq,
   input  logic        irq_clr
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [5:0] DW6 = 6'(DATA_WIDTH);

   typedef enum logic [1:0] {IDLE, SYNC, SHIFT, WAIT} state_t;

   // Places the n captured LSBs of bits at [31:32-n], zero below.
   function automatic logic [31:0] justify(input logic [DATA_WIDTH-1:0] bits,
                                           input logic [5:0] n);
      return 32'(bits) << (6'd32 - n);
   endfunction

   logic sclk_p0, sclk_p1, sclk_p2;
   logic lr_p0, lr_p1;
   logic sd_p0, sd_p1;

   // Stage p0/p1: synchronisers; p2: sclk edge detect
   always_ff @(posedge aud_mclk or negedge aud_mrst_n) begin
      if (!aud_mrst_n) begin
         sclk_p0 <= 1'b0;
         sclk_p1 <= 1'b0;
         sclk_p2 <= 1'b0;
         lr_p0   <= 1'b0;
         lr_p1   <= 1'b0;
         sd_p0   <= 1'b0;
         sd_p1   <= 1'b0;
      end else begin
         sclk_p0 <= sclk_in;
         sclk_p1 <= sclk_p0;
         sclk_p2 <= sclk_p1;
         lr_p0   <= lrclk_in;
         lr_p1   <= lr_p0;
         sd_p0   <= sdata_0_in;
         sd_p1   <= sd_p0;
      end
   end

   logic sclk_rise;
   logic trans;
   assign sclk_rise = sclk_p1 & ~sclk_p2;

   state_t                  state;
   logic                    lr_prev;
   logic                    chan;
   logic [5:0]              bit_cnt;
   logic [DATA_WIDTH-1:0]   shift_reg;
   logic [DATA_WIDTH-1:0]   shift_nxt;
   logic                    push_vld_p1;
   logic [31:0]             push_data_p1;
   logic                    push_chan_p1;

   assign trans     = lr_p1 != lr_prev;
   assign shift_nxt = {shift_reg[DATA_WIDTH-2:0], sd_p1};

   always_ff @(posedge aud_mclk or negedge aud_mrst_n) begin
      if (!aud_mrst_n) begin
         state       <= IDLE;
         lr_prev     <= 1'b0;
         chan        <= 1'b0;
         bit_cnt     <= '0;
         push_vld_p1 <= 1'b0;
      end else begin
         push_vld_p1 <= 1'b0;
         if (!enable) begin
            state <= IDLE;
         end else if (sclk_rise) begin
            lr_prev <= lr_p1;
            case (state)
               IDLE: state <= SYNC;
               SYNC, WAIT: begin
                  if (trans) begin
                     chan    <= lr_p1;
                     bit_cnt <= '0;
                     state   <= SHIFT;
                  end
               end
               SHIFT: begin
                  // A transition here is both a short-frame end and the new delay slot
                  if (trans) begin
                     push_vld_p1 <= 1'b1;
                     chan        <= lr_p1;
                     bit_cnt     <= '0;
                  end else begin
                     bit_cnt <= bit_cnt + 6'd1;
                     if (bit_cnt + 6'd1 == DW6) begin
                        push_vld_p1 <= 1'b1;
                        state       <= WAIT;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   // Stage p1: push word formed from the sclk_rise that completed it
   always_ff @(posedge aud_mclk) begin
      if (sclk_rise) begin
         shift_reg    <= trans ? '0 : shift_nxt;
         push_data_p1 <= trans ? justify(shift_reg, bit_cnt) : justify(shift_nxt, DW6);
         push_chan_p1 <= chan;
      end
   end

   logic [32:0]      mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_nxt;
   logic [CNT_W-1:0] count, cnt_nxt;
   logic             do_pop, do_push, full, drop;
   logic [32:0]      head;

   assign full    = count == CNT_W'(FIFO_DEPTH);
   assign do_pop  = m_axis_aud_tvalid & m_axis_aud_tready;
   assign do_push = push_vld_p1 & (~full | do_pop);
   assign drop    = push_vld_p1 & full & ~do_pop;
   assign rd_nxt  = do_pop ? rd_ptr + PTR_W'(1) : rd_ptr;
   assign cnt_nxt = count + CNT_W'(do_push) - CNT_W'(do_pop);
   // The freshly written entry becomes head only when it lands at the new read pointer
   assign head    = (do_push && wr_ptr == rd_nxt) ? {push_chan_p1, push_data_p1} : mem[rd_nxt];

   always_ff @(posedge aud_mclk) begin
      if (do_push) mem[wr_ptr] <= {push_chan_p1, push_data_p1};
   end

   // Stage p2: registered FIFO head and status
   always_ff @(posedge aud_mclk or negedge aud_mrst_n) begin
      if (!aud_mrst_n) begin
         wr_ptr            <= '0;
         rd_ptr            <= '0;
         count             <= '0;
         m_axis_aud_tvalid <= 1'b0;
         m_axis_aud_tdata  <= '0;
         m_axis_aud_tid    <= 1'b0;
         overflow          <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         rd_ptr            <= rd_nxt;
         count             <= cnt_nxt;
         m_axis_aud_tvalid <= cnt_nxt != '0;
         if (cnt_nxt != '0) {m_axis_aud_tid, m_axis_aud_tdata} <= head;
         if (drop)         overflow <= 1'b1;
         else if (irq_clr) overflow <= 1'b0;
      end
   end

   assign irq = overflow;

endmodule
